// File: rtl/conv_k3_pkg.sv
// Shared definitions for the K=3, rate-1/2 (7,5) convolutional code.
// The encoder uses them, and so can the decoder's path_id logic and any checker.
package conv_k3_pkg;

  localparam logic [2:0] G1 = 3'b111;
  localparam logic [2:0] G0 = 3'b101;
  localparam int K = 3;
  localparam int STATE_W = K - 1;

  typedef enum logic [1:0] {S_DATA, S_TAIL1, S_TAIL2} fsm_t;

  // Code symbol {c1,c0} for input u leaving state {u(t-1),u(t-2)}
  function automatic logic [1:0] branch_sym(input logic [STATE_W-1:0] state, input logic u);
    logic [K-1:0] taps;
    taps = {u, state};
    return {^(taps & G1), ^(taps & G0)};
  endfunction

  // New state MSB is the input bit, matching the decoder's state numbering
  function automatic logic [STATE_W-1:0] branch_next(input logic [STATE_W-1:0] state, input logic u);
    return {u, state[STATE_W-1:1]};
  endfunction

endpackage

// File: rtl/conv_k3_branch.sv
// One trellis branch of the (7,5) code: maps (state, input bit) to (symbol, next state).
module conv_k3_branch
  import conv_k3_pkg::*;
(
  input  logic [STATE_W-1:0] s,
  input  logic               u,
  output logic [1:0]         sym,
  output logic [STATE_W-1:0] next_s
);

  assign sym    = branch_sym(s, u);
  assign next_s = branch_next(s, u);

endmodule

// File: rtl/conv_encoder_k3.sv
// Rate-1/2 K=3 convolutional encoder with optional 2-bit zero tail per frame,
// a single-entry output register with valid/ready handshake on both sides.
module conv_encoder_k3
  import conv_k3_pkg::*;
#(
  parameter int TAIL_EN  = 1,
  parameter int MAX_INFO = 254,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sym,
  output logic       out_last,
  output logic       overflow,
  output logic       busy
);

  fsm_t               fsm_reg;
  logic [STATE_W-1:0] s_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic               out_slot;
  logic               accept;
  logic               u_sel;
  logic [1:0]         br_sym;
  logic [STATE_W-1:0] br_next;
  logic [CNT_W:0]     cnt_inc;
  logic               forced_end;
  logic               frame_end;

  assign out_slot   = !out_valid || out_ready;
  assign in_ready   = (fsm_reg == S_DATA) && out_slot;
  assign accept     = in_valid && in_ready;
  // Tail states feed zeros through the same branch logic
  assign u_sel      = (fsm_reg == S_DATA) ? in_bit : 1'b0;
  assign cnt_inc    = {1'b0, cnt_reg} + (CNT_W+1)'(1);
  assign forced_end = (cnt_inc == (CNT_W+1)'(MAX_INFO));
  assign frame_end  = in_last || forced_end;
  assign busy       = (cnt_reg != '0) || (fsm_reg != S_DATA);

  conv_k3_branch u_branch (
    .s      (s_reg),
    .u      (u_sel),
    .sym    (br_sym),
    .next_s (br_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_reg   <= S_DATA;
      s_reg     <= '0;
      cnt_reg   <= '0;
      out_valid <= 1'b0;
      out_sym   <= 2'b00;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // Drained symbol clears valid unless a new one is loaded below
      if (out_ready) out_valid <= 1'b0;
      case (fsm_reg)
        S_DATA: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_sym   <= br_sym;
            out_last  <= 1'b0;
            s_reg     <= br_next;
            cnt_reg   <= cnt_inc[CNT_W-1:0];
            if (forced_end && !in_last) overflow <= 1'b1;
            if (frame_end) begin
              if (TAIL_EN != 0) begin
                fsm_reg <= S_TAIL1;
              end else begin
                out_last <= 1'b1;
                s_reg    <= '0;
                cnt_reg  <= '0;
              end
            end
          end
        end
        S_TAIL1: begin
          if (out_slot) begin
            out_valid <= 1'b1;
            out_sym   <= br_sym;
            out_last  <= 1'b0;
            s_reg     <= br_next;
            fsm_reg   <= S_TAIL2;
          end
        end
        S_TAIL2: begin
          if (out_slot) begin
            out_valid <= 1'b1;
            out_sym   <= br_sym;
            out_last  <= 1'b1;
            s_reg     <= br_next;
            cnt_reg   <= '0;
            fsm_reg   <= S_DATA;
          end
        end
        default: fsm_reg <= S_DATA;
      endcase
    end
  end

endmodule
